// File: rtl/tlb_lookup.sv
// 8-entry fully associative TLB: single-cycle registered lookup, indexed write, invalidate sweep FSM.
// Optional macro TLB_HUGEPAGE_EN: entries with ps==21 match on vppn[18:9] and take the odd bit from vppn[8].
module tlb_lookup (
  input  logic        clk,
  input  logic        reset,
  input  logic        lkp_req,
  output logic        lkp_ready,
  input  logic [18:0] lkp_vppn,
  input  logic        lkp_odd,
  input  logic [9:0]  lkp_asid,
  output logic        lkp_valid,
  output logic        lkp_found,
  output logic [2:0]  lkp_idx,
  output logic [19:0] lkp_pfn,
  output logic [1:0]  lkp_mat,
  output logic [1:0]  lkp_plv,
  output logic        lkp_d,
  output logic        lkp_v,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic        wr_e,
  input  logic [18:0] wr_vppn,
  input  logic [5:0]  wr_ps,
  input  logic [9:0]  wr_asid,
  input  logic        wr_g,
  input  logic [25:0] wr_lo0,
  input  logic [25:0] wr_lo1,
  input  logic        inv_req,
  input  logic [2:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vppn,
  output logic        inv_busy,
  output logic        inv_done
);
  localparam int NENT = 8;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state_q;
  logic [2:0]  sweep_idx_q;
  logic        inv_busy_q, inv_done_q;

  logic        e_q    [NENT];
  logic        e_d    [NENT];
  logic [18:0] vppn_q [NENT];
  logic [18:0] vppn_d [NENT];
  logic [5:0]  ps_q   [NENT];
  logic [5:0]  ps_d   [NENT];
  logic [9:0]  asid_q [NENT];
  logic [9:0]  asid_d [NENT];
  logic        g_q    [NENT];
  logic        g_d    [NENT];
  logic [25:0] lo0_q  [NENT];
  logic [25:0] lo0_d  [NENT];
  logic [25:0] lo1_q  [NENT];
  logic [25:0] lo1_d  [NENT];
  logic        huge   [NENT];

  logic [2:0]  inv_op_q, inv_op_d;
  logic [9:0]  inv_asid_q, inv_asid_d;
  logic [18:0] inv_vppn_q, inv_vppn_d;

  logic        lkp_valid_q, lkp_valid_d;
  logic        lkp_found_q, lkp_found_d;
  logic [2:0]  lkp_idx_q, lkp_idx_d;
  logic [25:0] lkp_lo_q, lkp_lo_d;

  logic        lkp_acc, accept_inv;
  logic        hit_found;
  logic [2:0]  hit_idx;
  logic [25:0] hit_lo;
  logic        sw_asid_m, sw_vppn_m, sweep_clr;

  function automatic logic vppn_eq(input logic [18:0] a, input logic [18:0] b, input logic is_huge);
    if (is_huge) return a[18:9] == b[18:9];
    return a == b;
  endfunction

  function automatic logic inv_sel(input logic [2:0] op, input logic g, input logic am, input logic vm);
    case (op)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return g;
      3'd3:       return ~g;
      3'd4:       return ~g & am;
      3'd5:       return ~g & am & vm;
      3'd6:       return (g | am) & vm;
      default:    return 1'b0;
    endcase
  endfunction

`ifdef TLB_HUGEPAGE_EN
  always_comb begin
    for (int i = 0; i < NENT; i++) huge[i] = (ps_q[i] == 6'd21);
  end
`else
  logic unused_ps;
  always_comb begin
    unused_ps = 1'b0;
    for (int i = 0; i < NENT; i++) begin
      huge[i]   = 1'b0;
      unused_ps = unused_ps ^ (^ps_q[i]);
    end
  end
`endif

  assign lkp_ready  = ~inv_busy_q;
  assign inv_busy   = inv_busy_q;
  assign inv_done   = inv_done_q;
  assign lkp_acc    = lkp_req & lkp_ready;
  assign accept_inv = (state_q == IDLE) & inv_req;

  // Lookup: descending scan so the lowest-index hit wins.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = 3'd0;
    hit_lo    = 26'd0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (e_q[i] && (g_q[i] || (asid_q[i] == lkp_asid)) && vppn_eq(vppn_q[i], lkp_vppn, huge[i])) begin
        hit_found = 1'b1;
        hit_idx   = 3'(i);
        hit_lo    = (huge[i] ? lkp_vppn[8] : lkp_odd) ? lo1_q[i] : lo0_q[i];
      end
    end
  end

  always_comb begin
    sw_asid_m = (asid_q[sweep_idx_q] == inv_asid_q);
    sw_vppn_m = vppn_eq(vppn_q[sweep_idx_q], inv_vppn_q, huge[sweep_idx_q]);
    sweep_clr = (state_q == SWEEP) && inv_sel(inv_op_q, g_q[sweep_idx_q], sw_asid_m, sw_vppn_m);
  end

  // Entry update: the sweep clear is applied first so a same-index write overrides it.
  always_comb begin
    e_d    = e_q;
    vppn_d = vppn_q;
    ps_d   = ps_q;
    asid_d = asid_q;
    g_d    = g_q;
    lo0_d  = lo0_q;
    lo1_d  = lo1_q;
    if (sweep_clr) e_d[sweep_idx_q] = 1'b0;
    if (wr_en) begin
      e_d[wr_idx]    = wr_e;
      vppn_d[wr_idx] = wr_vppn;
      ps_d[wr_idx]   = wr_ps;
      asid_d[wr_idx] = wr_asid;
      g_d[wr_idx]    = wr_g;
      lo0_d[wr_idx]  = wr_lo0;
      lo1_d[wr_idx]  = wr_lo1;
    end
  end

  always_comb begin
    inv_op_d    = accept_inv ? inv_op   : inv_op_q;
    inv_asid_d  = accept_inv ? inv_asid : inv_asid_q;
    inv_vppn_d  = accept_inv ? inv_vppn : inv_vppn_q;
    lkp_valid_d = lkp_acc;
    lkp_found_d = lkp_acc ? hit_found : lkp_found_q;
    lkp_idx_d   = lkp_acc ? hit_idx   : lkp_idx_q;
    lkp_lo_d    = lkp_acc ? hit_lo    : lkp_lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NENT; i++) e_q[i] <= 1'b0;
      lkp_valid_q <= 1'b0;
      lkp_found_q <= 1'b0;
      lkp_idx_q   <= 3'd0;
      lkp_lo_q    <= 26'd0;
    end else begin
      e_q         <= e_d;
      lkp_valid_q <= lkp_valid_d;
      lkp_found_q <= lkp_found_d;
      lkp_idx_q   <= lkp_idx_d;
      lkp_lo_q    <= lkp_lo_d;
    end
  end

  always_ff @(posedge clk) begin
    vppn_q     <= vppn_d;
    ps_q       <= ps_d;
    asid_q     <= asid_d;
    g_q        <= g_d;
    lo0_q      <= lo0_d;
    lo1_q      <= lo1_d;
    inv_op_q   <= inv_op_d;
    inv_asid_q <= inv_asid_d;
    inv_vppn_q <= inv_vppn_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sweep_idx_q <= 3'd0;
      inv_busy_q  <= 1'b0;
      inv_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          inv_done_q <= 1'b0;
          if (inv_req) begin
            state_q     <= SWEEP;
            sweep_idx_q <= 3'd0;
            inv_busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_idx_q == 3'd7) begin
            state_q    <= DONE;
            inv_done_q <= 1'b1;
          end else begin
            sweep_idx_q <= sweep_idx_q + 3'd1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          inv_busy_q <= 1'b0;
          inv_done_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          inv_busy_q <= 1'b0;
          inv_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign lkp_valid = lkp_valid_q;
  assign lkp_found = lkp_found_q;
  assign lkp_idx   = lkp_idx_q;
  assign lkp_pfn   = lkp_lo_q[25:6];
  assign lkp_mat   = lkp_lo_q[5:4];
  assign lkp_plv   = lkp_lo_q[3:2];
  assign lkp_d     = lkp_lo_q[1];
  assign lkp_v     = lkp_lo_q[0];
endmodule

// File: tb/tb_tlb_lookup.sv
// Directed bench for tlb_lookup: a table-level reference model checked every cycle plus literal expectations.
module tb_tlb_lookup;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lkp_req = 1'b0, lkp_ready;
  logic [18:0] lkp_vppn = '0;
  logic        lkp_odd = 1'b0;
  logic [9:0]  lkp_asid = '0;
  logic        lkp_valid, lkp_found, lkp_d, lkp_v;
  logic [2:0]  lkp_idx;
  logic [19:0] lkp_pfn;
  logic [1:0]  lkp_mat, lkp_plv;
  logic        wr_en = 1'b0, wr_e = 1'b0, wr_g = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [18:0] wr_vppn = '0;
  logic [5:0]  wr_ps = '0;
  logic [9:0]  wr_asid = '0;
  logic [25:0] wr_lo0 = '0, wr_lo1 = '0;
  logic        inv_req = 1'b0;
  logic [2:0]  inv_op = '0;
  logic [9:0]  inv_asid = '0;
  logic [18:0] inv_vppn = '0;
  logic        inv_busy, inv_done;

`ifdef TLB_HUGEPAGE_EN
  localparam bit HUGE_ON = 1'b1;
`else
  localparam bit HUGE_ON = 1'b0;
`endif

  tlb_lookup dut (
    .clk(clk), .reset(reset),
    .lkp_req(lkp_req), .lkp_ready(lkp_ready), .lkp_vppn(lkp_vppn), .lkp_odd(lkp_odd), .lkp_asid(lkp_asid),
    .lkp_valid(lkp_valid), .lkp_found(lkp_found), .lkp_idx(lkp_idx), .lkp_pfn(lkp_pfn),
    .lkp_mat(lkp_mat), .lkp_plv(lkp_plv), .lkp_d(lkp_d), .lkp_v(lkp_v),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_e(wr_e), .wr_vppn(wr_vppn), .wr_ps(wr_ps), .wr_asid(wr_asid),
    .wr_g(wr_g), .wr_lo0(wr_lo0), .wr_lo1(wr_lo1),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_busy(inv_busy), .inv_done(inv_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the TLB as a table, the sweep as a position counter.
  bit          m_e    [8];
  logic [18:0] m_vppn [8];
  logic [5:0]  m_ps   [8];
  logic [9:0]  m_asid [8];
  bit          m_g    [8];
  logic [25:0] m_lo0  [8];
  logic [25:0] m_lo1  [8];
  int          m_pos;
  logic [2:0]  m_op;
  logic [9:0]  m_ias;
  logic [18:0] m_ivp;
  bit          x_valid = 0, x_found = 0, x_busy = 0, x_done = 0;
  int          x_idx = 0;
  logic [25:0] x_lo = '0;

  function automatic bit m_huge(input int i);
    return HUGE_ON && (m_ps[i] == 6'd21);
  endfunction

  function automatic bit m_vmatch(input int i, input logic [18:0] q);
    if (m_huge(i)) return m_vppn[i][18:9] == q[18:9];
    return m_vppn[i] == q;
  endfunction

  function automatic bit m_inv_hits(input int i);
    bit am, vm;
    am = (m_asid[i] == m_ias);
    vm = m_vmatch(i, m_ivp);
    case (m_op)
      3'd0, 3'd1: return 1'b1;
      3'd2: return m_g[i];
      3'd3: return !m_g[i];
      3'd4: return !m_g[i] && am;
      3'd5: return !m_g[i] && am && vm;
      3'd6: return (m_g[i] || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    m_pos = -1;
    for (int i = 0; i < 8; i++) m_e[i] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 8; i++) m_e[i] = 0;
        m_pos = -1;
        x_valid = 0; x_found = 0; x_idx = 0; x_lo = '0; x_busy = 0; x_done = 0;
      end else begin
        x_valid = lkp_req && !x_busy;
        if (x_valid) begin
          x_found = 0; x_idx = 0; x_lo = '0;
          for (int i = 0; i < 8; i++) begin
            if (!x_found && m_e[i] && (m_g[i] || m_asid[i] == lkp_asid) && m_vmatch(i, lkp_vppn)) begin
              x_found = 1;
              x_idx = i;
              x_lo = ((m_huge(i) ? lkp_vppn[8] : lkp_odd) == 1'b1) ? m_lo1[i] : m_lo0[i];
            end
          end
        end
        if (m_pos >= 0 && m_pos < 8) begin
          if (m_inv_hits(m_pos)) m_e[m_pos] = 0;
          m_pos++;
        end else if (m_pos == 8) begin
          m_pos = -1;
        end else if (inv_req) begin
          m_pos = 0; m_op = inv_op; m_ias = inv_asid; m_ivp = inv_vppn;
        end
        if (wr_en) begin
          m_e[wr_idx] = wr_e; m_vppn[wr_idx] = wr_vppn; m_ps[wr_idx] = wr_ps;
          m_asid[wr_idx] = wr_asid; m_g[wr_idx] = wr_g; m_lo0[wr_idx] = wr_lo0; m_lo1[wr_idx] = wr_lo1;
        end
        x_busy = (m_pos >= 0);
        x_done = (m_pos == 8);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid", 32'(lkp_valid), 32'(x_valid));
      check("ready", 32'(lkp_ready), 32'(!x_busy));
      check("busy", 32'(inv_busy), 32'(x_busy));
      check("done", 32'(inv_done), 32'(x_done));
      if (x_valid) begin
        check("found", 32'(lkp_found), 32'(x_found));
        check("idx", 32'(lkp_idx), 32'(x_idx));
        check("pfn", 32'(lkp_pfn), 32'(x_lo[25:6]));
        check("mat", 32'(lkp_mat), 32'(x_lo[5:4]));
        check("plv", 32'(lkp_plv), 32'(x_lo[3:2]));
        check("d", 32'(lkp_d), 32'(x_lo[1]));
        check("v", 32'(lkp_v), 32'(x_lo[0]));
      end
    end
  end

  function automatic logic [25:0] mk_lo(input logic [19:0] pfn, input logic [1:0] mat,
                                        input logic [1:0] plv, input bit d, input bit v);
    return {pfn, mat, plv, d, v};
  endfunction

  task automatic wr_entry(input int idx, input bit e, input logic [18:0] vppn, input logic [5:0] ps,
                          input logic [9:0] asid, input bit g, input logic [25:0] lo0, input logic [25:0] lo1);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_e = e; wr_vppn = vppn; wr_ps = ps;
    wr_asid = asid; wr_g = g; wr_lo0 = lo0; wr_lo1 = lo1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [18:0] vppn, input bit odd, input logic [9:0] asid);
    lkp_req = 1'b1; lkp_vppn = vppn; lkp_odd = odd; lkp_asid = asid;
    @(negedge clk);
    lkp_req = 1'b0;
  endtask

  task automatic start_inv(input logic [2:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    inv_req = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    @(negedge clk);
    inv_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (inv_busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(inv_busy), 32'd0);
  endtask

  initial begin
    int nb, nd, done_k, rdy_busy;
    logic [2:0] ops [5];
    ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd5; ops[3] = 3'd6; ops[4] = 3'd7;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", 32'(lkp_valid), 32'd0);
    check("rst_found", 32'(lkp_found), 32'd0);
    check("rst_idx", 32'(lkp_idx), 32'd0);
    check("rst_pfn", 32'(lkp_pfn), 32'd0);
    check("rst_ready", 32'(lkp_ready), 32'd1);
    check("rst_busy", 32'(inv_busy), 32'd0);
    check("rst_done", 32'(inv_done), 32'd0);

    // Basic hit on the odd page
    wr_entry(2, 1, 19'h00012, 6'd12, 10'd5, 0, 26'd0, mk_lo(20'hABCDE, 2'd0, 2'd0, 0, 1));
    lookup(19'h00012, 1, 10'd5);
    check("b_valid", 32'(lkp_valid), 32'd1);
    check("b_found", 32'(lkp_found), 32'd1);
    check("b_idx", 32'(lkp_idx), 32'd2);
    check("b_pfn", 32'(lkp_pfn), 32'hABCDE);
    check("b_v", 32'(lkp_v), 32'd1);

    // ASID mismatch, then global
    lookup(19'h00012, 1, 10'd6);
    check("asid_found", 32'(lkp_found), 32'd0);
    check("asid_pfn", 32'(lkp_pfn), 32'd0);
    wr_entry(2, 1, 19'h00012, 6'd12, 10'd5, 1, 26'd0, mk_lo(20'hABCDE, 2'd0, 2'd0, 0, 1));
    lookup(19'h00012, 1, 10'd6);
    check("glob_found", 32'(lkp_found), 32'd1);
    lookup(19'h00012, 0, 10'd6);
    check("even_pfn", 32'(lkp_pfn), 32'd0);

    // Priority among identical entries
    wr_entry(6, 1, 19'h00300, 6'd12, 10'd9, 0, mk_lo(20'h11111, 2'd2, 2'd3, 1, 1), 26'd0);
    wr_entry(3, 1, 19'h00300, 6'd12, 10'd9, 0, mk_lo(20'h11111, 2'd2, 2'd3, 1, 1), 26'd0);
    lookup(19'h00300, 0, 10'd9);
    check("prio_idx", 32'(lkp_idx), 32'd3);
    check("prio_mat", 32'(lkp_mat), 32'd2);
    wr_entry(3, 0, 19'h00300, 6'd12, 10'd9, 0, 26'd0, 26'd0);
    lookup(19'h00300, 0, 10'd9);
    check("prio2_idx", 32'(lkp_idx), 32'd6);

    // Lookup in the write cycle sees old contents
    wr_en = 1'b1; wr_idx = 3'd6; wr_e = 1'b1; wr_vppn = 19'h00300; wr_ps = 6'd12;
    wr_asid = 10'd9; wr_g = 1'b0; wr_lo0 = mk_lo(20'h22222, 2'd1, 2'd1, 0, 1); wr_lo1 = 26'd0;
    lookup(19'h00300, 0, 10'd9);
    wr_en = 1'b0;
    check("wrsame_pfn", 32'(lkp_pfn), 32'h11111);
    lookup(19'h00300, 0, 10'd9);
    check("wrnext_pfn", 32'(lkp_pfn), 32'h22222);

    // op4 sweep with a lookup accepted alongside it
    wr_entry(0, 1, 19'h00010, 6'd12, 10'd5, 0, mk_lo(20'h00A00, 2'd0, 2'd0, 0, 1), 26'd0);
    wr_entry(1, 1, 19'h00011, 6'd12, 10'd5, 1, mk_lo(20'h00A01, 2'd0, 2'd0, 0, 1), 26'd0);
    wr_entry(2, 1, 19'h00012, 6'd12, 10'd7, 0, mk_lo(20'h00A02, 2'd0, 2'd0, 0, 1), 26'd0);
    inv_req = 1'b1; inv_op = 3'd4; inv_asid = 10'd5; inv_vppn = 19'd0;
    lkp_req = 1'b1; lkp_vppn = 19'h00010; lkp_odd = 1'b0; lkp_asid = 10'd5;
    @(negedge clk);
    check("same_found", 32'(lkp_found), 32'd1);
    check("same_idx", 32'(lkp_idx), 32'd0);
    nb = 0; nd = 0; done_k = -1; rdy_busy = 0;
    for (int k = 0; k < 30 && inv_busy; k++) begin
      nb++;
      if (inv_done) begin nd++; done_k = k; end
      if (lkp_ready) rdy_busy++;
      if (k == 2) begin inv_req = 1'b0; lkp_req = 1'b0; end
      @(negedge clk);
    end
    inv_req = 1'b0; lkp_req = 1'b0;
    check("sweep_busy_cycles", 32'(nb), 32'd9);
    check("sweep_done_count", 32'(nd), 32'd1);
    check("sweep_done_pos", 32'(done_k), 32'd8);
    check("sweep_ready_hi", 32'(rdy_busy), 32'd0);
    lookup(19'h00010, 0, 10'd5);
    check("op4_e0_found", 32'(lkp_found), 32'd0);
    lookup(19'h00011, 0, 10'd5);
    check("op4_e1_found", 32'(lkp_found), 32'd1);
    lookup(19'h00012, 0, 10'd7);
    check("op4_e2_idx", 32'(lkp_idx), 32'd2);

    // Clear-all sweep with a write to the entry being swept
    start_inv(3'd0, 10'd0, 19'd0);
    repeat (4) @(negedge clk);
    wr_entry(4, 1, 19'h00045, 6'd12, 10'd1, 0, mk_lo(20'h44444, 2'd0, 2'd0, 0, 1), 26'd0);
    wait_idle("op0_idle");
    lookup(19'h00045, 0, 10'd1);
    check("wwin_found", 32'(lkp_found), 32'd1);
    check("wwin_pfn", 32'(lkp_pfn), 32'h44444);
    lookup(19'h00011, 0, 10'd5);
    check("op0_found", 32'(lkp_found), 32'd0);

    // Remaining invalidate ops over a fixed table, probed entry by entry
    foreach (ops[j]) begin
      for (int i = 0; i < 8; i++)
        wr_entry(i, 1, 19'h00100 + 19'(i), 6'd12, (i < 4) ? 10'd5 : 10'd8, i[0],
                 mk_lo(20'h01000 + 20'(i), 2'd0, 2'd0, 0, 1), 26'd0);
      start_inv(ops[j], 10'd5, 19'h00102);
      wait_idle("ops_idle");
      for (int i = 0; i < 8; i++) lookup(19'h00100 + 19'(i), 0, (i < 4) ? 10'd5 : 10'd8);
      if (ops[j] == 3'd5) begin
        lookup(19'h00102, 0, 10'd5);
        check("op5_e2_found", 32'(lkp_found), 32'd0);
      end
    end

    // Huge page
    wr_entry(7, 1, 19'h40000, 6'd21, 10'd3, 0, mk_lo(20'h0F0F0, 2'd0, 2'd0, 0, 1),
             mk_lo(20'h5A5A5, 2'd1, 2'd0, 1, 1));
    lookup(19'h401FF, 0, 10'd3);
`ifdef TLB_HUGEPAGE_EN
    check("huge_found", 32'(lkp_found), 32'd1);
    check("huge_pfn", 32'(lkp_pfn), 32'h5A5A5);
`else
    check("huge_found", 32'(lkp_found), 32'd0);
`endif
    lookup(19'h40000, 1, 10'd3);

    // Reset in the middle of a sweep
    start_inv(3'd7, 10'd0, 19'd0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mrst_busy", 32'(inv_busy), 32'd0);
    check("mrst_done", 32'(inv_done), 32'd0);
    check("mrst_ready", 32'(lkp_ready), 32'd1);
    check("mrst_valid", 32'(lkp_valid), 32'd0);
    check("mrst_found", 32'(lkp_found), 32'd0);
    check("mrst_pfn", 32'(lkp_pfn), 32'd0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      if (inv_done) nd++;
    end
    check("mrst_no_done", 32'(nd), 32'd0);
    lookup(19'h40000, 1, 10'd3);
    check("mrst_e7_found", 32'(lkp_found), 32'd0);
    lookup(19'h00100, 0, 10'd5);
    check("mrst_e0_found", 32'(lkp_found), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
